// File: rtl/interrupt_dispatcher.sv
// Interrupt dispatcher: arbitrates Interrupt_Register sources, requests, acks, clears buttons.
// Optional ack timeout in REQ is built when INT_ACK_TIMEOUT_EN is defined.
module interrupt_dispatcher #(
    parameter logic [15:0] VEC_BASE  = 16'h0100,
    parameter int          VEC_SHIFT = 4
`ifdef INT_ACK_TIMEOUT_EN
    , parameter int        ACK_TIMEOUT = 255
`endif
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  State,
    input  logic [7:0]  IntEnable,
    input  logic        IntAck,
    input  logic        IntDone,
    output logic        IntReq,
    output logic [15:0] IntVector,
    output logic [2:0]  IntCause,
    output logic [3:0]  CLR,
    output logic        Busy
);
    typedef enum logic [1:0] {IDLE, REQ, ACK, SERVICE} state_t;

    state_t      state;
    logic [3:0]  sw_hist;
    logic [3:0]  sw_pend;
    logic [3:0]  sw_clr;
    logic [7:0]  cand;
    logic [2:0]  win;
    logic [15:0] win_vec;

    assign cand = {State[7:4], sw_pend} & IntEnable;

    // Ascending scan so the highest set index is the one left in win.
    always_comb begin
        win = 3'd0;
        for (int i = 0; i < 8; i++)
            if (cand[i]) win = 3'(i);
    end

    assign win_vec = VEC_BASE + ({13'd0, win} << VEC_SHIFT);

    assign sw_clr = (state == ACK && !IntCause[2]) ? (4'b0001 << IntCause[1:0]) : 4'b0000;

    // History resets high so a switch held through reset produces no edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sw_hist <= 4'b1111;
            sw_pend <= 4'b0000;
        end else begin
            sw_hist <= State[3:0];
            sw_pend <= (sw_pend & ~sw_clr) | (State[3:0] & ~sw_hist);
        end
    end

`ifdef INT_ACK_TIMEOUT_EN
    logic [7:0] to_cnt;
    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            IntReq    <= 1'b0;
            IntVector <= VEC_BASE;
            IntCause  <= 3'd0;
            CLR       <= 4'b0000;
            Busy      <= 1'b0;
`ifdef INT_ACK_TIMEOUT_EN
            to_cnt    <= 8'd0;
`endif
        end else begin
            CLR <= 4'b0000;
            case (state)
                IDLE: begin
                    if (cand != 8'd0) begin
                        state     <= REQ;
                        IntReq    <= 1'b1;
                        IntCause  <= win;
                        IntVector <= win_vec;
                        Busy      <= 1'b1;
`ifdef INT_ACK_TIMEOUT_EN
                        to_cnt    <= 8'd0;
`endif
                    end
                end
                REQ: begin
                    if (IntAck) begin
                        state  <= ACK;
                        IntReq <= 1'b0;
                        if (IntCause[2]) CLR <= 4'b0001 << IntCause[1:0];
`ifdef INT_ACK_TIMEOUT_EN
                    end else if (to_cnt == TO_LAST) begin
                        // Source remains pending and is re-arbitrated from IDLE.
                        state  <= IDLE;
                        IntReq <= 1'b0;
                        Busy   <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
`endif
                    end
                end
                ACK: state <= SERVICE;
                SERVICE: begin
                    if (IntDone) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    IntReq <= 1'b0;
                    Busy   <= 1'b0;
                end
            endcase
        end
    end
endmodule
